// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Register-file geometry and well-known register numbers.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [NUM_REGS-1:0]   wen_t;
  typedef logic [REG_ADDR_W-1:0] raddr_t;

endpackage

// File: rtl/reg_cell.sv
// One architectural register: enable-gated flop,
// asynchronously cleared by an active-high reset.
module reg_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/reg_write_bank.sv
// MIPS register file write side: one write port,
// 32 registers presented in parallel, registered write-hit vector.
module reg_write_bank
  import mips_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  WE,
  input  logic [REG_ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0]     WData,
  output logic [DATA_W-1:0]     R0,
  output logic [DATA_W-1:0]     R1,
  output logic [DATA_W-1:0]     R2,
  output logic [DATA_W-1:0]     R3,
  output logic [DATA_W-1:0]     R4,
  output logic [DATA_W-1:0]     R5,
  output logic [DATA_W-1:0]     R6,
  output logic [DATA_W-1:0]     R7,
  output logic [DATA_W-1:0]     R8,
  output logic [DATA_W-1:0]     R9,
  output logic [DATA_W-1:0]     R10,
  output logic [DATA_W-1:0]     R11,
  output logic [DATA_W-1:0]     R12,
  output logic [DATA_W-1:0]     R13,
  output logic [DATA_W-1:0]     R14,
  output logic [DATA_W-1:0]     R15,
  output logic [DATA_W-1:0]     R16,
  output logic [DATA_W-1:0]     R17,
  output logic [DATA_W-1:0]     R18,
  output logic [DATA_W-1:0]     R19,
  output logic [DATA_W-1:0]     R20,
  output logic [DATA_W-1:0]     R21,
  output logic [DATA_W-1:0]     R22,
  output logic [DATA_W-1:0]     R23,
  output logic [DATA_W-1:0]     R24,
  output logic [DATA_W-1:0]     R25,
  output logic [DATA_W-1:0]     R26,
  output logic [DATA_W-1:0]     R27,
  output logic [DATA_W-1:0]     R28,
  output logic [DATA_W-1:0]     R29,
  output logic [DATA_W-1:0]     R30,
  output logic [DATA_W-1:0]     R31,
  output logic [NUM_REGS-1:0]   WrHit
);

  localparam bit HARD0 = (ZERO_HARDWIRED != 0);

  wen_t dec;
  wen_t wen;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_comb begin
    dec = '0;
    if (WE)
      dec[WAddr] = 1'b1;
  end

  // Hardwired R0 drops its enable so WrHit reports only real writes
  assign wen = HARD0 ? {dec[NUM_REGS-1:1], 1'b0} : dec;

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    if (n == 0 && HARD0) begin : g_zero
      assign regs[n] = '0;
    end else begin : g_cell
      reg_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk (Clk),
        .rst (Reset),
        .en  (wen[n]),
        .d   (WData),
        .q   (regs[n])
      );
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      WrHit <= '0;
    else
      WrHit <= wen;
  end

  assign R0  = regs[0];
  assign R1  = regs[1];
  assign R2  = regs[2];
  assign R3  = regs[3];
  assign R4  = regs[4];
  assign R5  = regs[5];
  assign R6  = regs[6];
  assign R7  = regs[7];
  assign R8  = regs[8];
  assign R9  = regs[9];
  assign R10 = regs[10];
  assign R11 = regs[11];
  assign R12 = regs[12];
  assign R13 = regs[13];
  assign R14 = regs[14];
  assign R15 = regs[15];
  assign R16 = regs[16];
  assign R17 = regs[17];
  assign R18 = regs[18];
  assign R19 = regs[19];
  assign R20 = regs[20];
  assign R21 = regs[21];
  assign R22 = regs[22];
  assign R23 = regs[23];
  assign R24 = regs[24];
  assign R25 = regs[25];
  assign R26 = regs[26];
  assign R27 = regs[27];
  assign R28 = regs[28];
  assign R29 = regs[29];
  assign R30 = regs[30];
  assign R31 = regs[31];

endmodule

// File: tb/tb_reg_write_bank.sv
// Bench for reg_write_bank: hardwired and ordinary-R0 instances
// checked against an array model of the register file.
module tb_reg_write_bank;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [31:0] rh [32];
  logic [31:0] rn [32];
  logic [31:0] hit_h;
  logic [31:0] hit_n;

  logic [31:0] mh [32];
  logic [31:0] mn [32];
  logic [31:0] eh;
  logic [31:0] en;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_write_bank #(.DATA_W(32), .ZERO_HARDWIRED(1)) u_hw (
    .Clk(clk), .Reset(rst), .WE(we), .WAddr(waddr), .WData(wdata),
    .R0(rh[0]), .R1(rh[1]), .R2(rh[2]), .R3(rh[3]),
    .R4(rh[4]), .R5(rh[5]), .R6(rh[6]), .R7(rh[7]),
    .R8(rh[8]), .R9(rh[9]), .R10(rh[10]), .R11(rh[11]),
    .R12(rh[12]), .R13(rh[13]), .R14(rh[14]), .R15(rh[15]),
    .R16(rh[16]), .R17(rh[17]), .R18(rh[18]), .R19(rh[19]),
    .R20(rh[20]), .R21(rh[21]), .R22(rh[22]), .R23(rh[23]),
    .R24(rh[24]), .R25(rh[25]), .R26(rh[26]), .R27(rh[27]),
    .R28(rh[28]), .R29(rh[29]), .R30(rh[30]), .R31(rh[31]),
    .WrHit(hit_h)
  );

  reg_write_bank #(.DATA_W(32), .ZERO_HARDWIRED(0)) u_nz (
    .Clk(clk), .Reset(rst), .WE(we), .WAddr(waddr), .WData(wdata),
    .R0(rn[0]), .R1(rn[1]), .R2(rn[2]), .R3(rn[3]),
    .R4(rn[4]), .R5(rn[5]), .R6(rn[6]), .R7(rn[7]),
    .R8(rn[8]), .R9(rn[9]), .R10(rn[10]), .R11(rn[11]),
    .R12(rn[12]), .R13(rn[13]), .R14(rn[14]), .R15(rn[15]),
    .R16(rn[16]), .R17(rn[17]), .R18(rn[18]), .R19(rn[19]),
    .R20(rn[20]), .R21(rn[21]), .R22(rn[22]), .R23(rn[23]),
    .R24(rn[24]), .R25(rn[25]), .R26(rn[26]), .R27(rn[27]),
    .R28(rn[28]), .R29(rn[29]), .R30(rn[30]), .R31(rn[31]),
    .WrHit(hit_n)
  );

  always @(posedge clk)
    if (we === 1'b1)
      assert (!$isunknown(waddr))
      else $error("FAIL waddr_x WE=1 with unknown WAddr");

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_hw_r%0d", tag, i), rh[i], mh[i]);
      chk($sformatf("%s_nz_r%0d", tag, i), rn[i], mn[i]);
    end
    chk({tag, "_hw_hit"}, hit_h, eh);
    chk({tag, "_nz_hit"}, hit_n, en);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mh[i] = '0;
      mn[i] = '0;
    end
    eh = '0;
    en = '0;
  endtask

  // Architectural meaning of one clock edge, then compare
  task automatic model_edge(input logic w, input logic [4:0] a,
                            input logic [31:0] d);
    eh = '0;
    en = '0;
    if (w) begin
      mn[a] = d;
      en = 32'h1 << a;
      if (a != 5'd0) begin
        mh[a] = d;
        eh = 32'h1 << a;
      end
    end
  endtask

  task automatic step(input logic w, input logic [4:0] a,
                      input logic [31:0] d, input string tag);
    we    = w;
    waddr = a;
    wdata = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("release");

    step(1'b1, 5'd5, 32'hDEADBEEF, "w5");
    chk("r5_direct", rh[5], 32'hDEADBEEF);
    chk("hit5_direct", hit_h, 32'h0000_0020);
    step(1'b0, 5'd5, 32'h0, "w5_idle");
    chk("hit5_gone", hit_h, 32'h0);

    step(1'b1, 5'd0, 32'hFFFFFFFF, "w0");
    chk("r0_hw_direct", rh[0], 32'h0);
    chk("hit0_hw_direct", hit_h, 32'h0);
    chk("r0_nz_direct", rn[0], 32'hFFFFFFFF);

    for (int c = 0; c < 4; c++)
      step(1'b0, 5'd7, 32'h12345678, "we0");

    step(1'b1, 5'd31, 32'h1, "ra1");
    chk("r31_first", rh[31], 32'h1);
    step(1'b1, 5'd31, 32'h2, "ra2");
    chk("r31_second", rh[31], 32'h2);
    chk("hit31_second", hit_h, 32'h8000_0000);

    for (int n = 1; n < 32; n++)
      step(1'b1, n[4:0], n, "fill");

    // Assert reset between edges with a write still presented
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst   = 1'b0;
    we    = 1'b1;
    waddr = 5'd3;
    wdata = 32'hA5A5A5A5;
    #1;
    check_all("deassert");
    step(1'b1, 5'd3, 32'hA5A5A5A5, "r3_land");
    chk("r3_direct", rh[3], 32'hA5A5A5A5);

    for (int k = 0; k < 1000; k++) begin
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      w = ($urandom_range(0, 3) != 0);
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      step(w, a, d, "rand");
      chk("rand_r0_zero", rh[0], 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
